// File: rtl/buf_audio_in_pkg.sv
// Shared constants, types and helpers for the buffered I2S audio input.
package buf_audio_in_pkg;

  localparam int I2S_WIDTH         = 24;
  localparam int AUDIO_WIDTH       = 24;
  localparam int BUFFER_DEPTH      = 8;
  localparam int STEREO_MULTIPLIER = 2;

  // Each pair FIFO stores interleaved mono words, two per stereo frame.
  localparam int FIFO_ENTRIES = STEREO_MULTIPLIER * BUFFER_DEPTH;
  localparam int PTR_W        = $clog2(FIFO_ENTRIES);
  localparam int CNT_W        = $clog2(FIFO_ENTRIES + 1);
  localparam int BITCNT_W     = 5;

  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_ENTRIES);
  localparam logic [CNT_W-1:0] CNT_READY = CNT_W'(STEREO_MULTIPLIER);

  // One FIFO entry: channel tag (0 = Left, 1 = Right) plus the sample.
  typedef struct packed {
    logic                   lr;
    logic [AUDIO_WIDTH-1:0] data;
  } mono_entry_t;

  // Frame assembly: Left write, one idle cycle, Right write.
  typedef enum logic [1:0] {
    ASM_IDLE  = 2'd0,
    ASM_GAP   = 2'd1,
    ASM_RIGHT = 2'd2
  } asm_state_t;

  // Circular pointer increment that also works for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(FIFO_ENTRIES - 1)) begin
      return '0;
    end
    return ptr + PTR_W'(1);
  endfunction

endpackage

// File: rtl/i2s_rx_deser.sv
// I2S receive front end: synchronises the pins into sys_clk, detects bclk
// rising edges and deserialises left-justified words, MSB first.
module i2s_rx_deser
  import buf_audio_in_pkg::*;
(
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 i2s_bclk_i,
  input  logic                 i2s_lrclk_i,
  input  logic                 i2s_data_i,
  output logic [I2S_WIDTH-1:0] word_o,
  output logic                 lr_o,
  output logic                 word_done_o
);

  localparam logic [BITCNT_W-1:0] LAST_BIT = BITCNT_W'(I2S_WIDTH - 1);

  logic bclk_meta_q, bclk_sync_q, bclk_prev_q;
  logic lrclk_meta_q, lrclk_sync_q;
  logic data_meta_q, data_sync_q;
  logic bclk_rise;

  logic [I2S_WIDTH-1:0] shift_q, shift_d;
  logic [BITCNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic                 lr_q, lr_d;
  logic                 lr_prev_q, lr_prev_d;
  logic                 seen_q, seen_d;
  logic                 active_q, active_d;
  logic                 done_q, done_d;

  // Two-flop synchronisers on all three pins plus bclk history for edge detect.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      bclk_meta_q  <= 1'b0;
      bclk_sync_q  <= 1'b0;
      bclk_prev_q  <= 1'b0;
      lrclk_meta_q <= 1'b0;
      lrclk_sync_q <= 1'b0;
      data_meta_q  <= 1'b0;
      data_sync_q  <= 1'b0;
    end else begin
      bclk_meta_q  <= i2s_bclk_i;
      bclk_sync_q  <= bclk_meta_q;
      bclk_prev_q  <= bclk_sync_q;
      lrclk_meta_q <= i2s_lrclk_i;
      lrclk_sync_q <= lrclk_meta_q;
      data_meta_q  <= i2s_data_i;
      data_sync_q  <= data_meta_q;
    end
  end

  assign bclk_rise = bclk_sync_q & ~bclk_prev_q;

  // Bit capture: a word starts at the rise that sees an lrclk change and
  // ends after I2S_WIDTH bits; later bits in the phase are ignored.
  // The first rise after reset only records lrclk so that reception
  // starts cleanly at the next real transition.
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    lr_d      = lr_q;
    lr_prev_d = lr_prev_q;
    seen_d    = seen_q;
    active_d  = active_q;
    done_d    = 1'b0;
    if (bclk_rise) begin
      seen_d    = 1'b1;
      lr_prev_d = lrclk_sync_q;
      if (seen_q && (lrclk_sync_q != lr_prev_q)) begin
        shift_d   = {shift_q[I2S_WIDTH-2:0], data_sync_q};
        bit_cnt_d = BITCNT_W'(1);
        lr_d      = lrclk_sync_q;
        active_d  = 1'b1;
      end else if (active_q) begin
        shift_d   = {shift_q[I2S_WIDTH-2:0], data_sync_q};
        bit_cnt_d = bit_cnt_q + BITCNT_W'(1);
        if (bit_cnt_q == LAST_BIT) begin
          done_d   = 1'b1;
          active_d = 1'b0;
        end
      end
    end
  end

  // Deserialiser state register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      lr_q      <= 1'b0;
      lr_prev_q <= 1'b0;
      seen_q    <= 1'b0;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      lr_q      <= lr_d;
      lr_prev_q <= lr_prev_d;
      seen_q    <= seen_d;
      active_q  <= active_d;
      done_q    <= done_d;
    end
  end

  assign word_o      = shift_q;
  assign lr_o        = lr_q;
  assign word_done_o = done_q;

endmodule

// File: rtl/i2s_buf_audio_in.sv
// Buffered I2S audio input: decodes one I2S lane, assembles stereo frames
// and fans them out into one interleaved FIFO per pair; pops land on a
// flat mono output array (index = pair*2 + lr).
// Optional build macro BUF_AUDIO_IN_OVERWRITE_EN: when defined, a write to a
// full FIFO evicts the oldest entry; otherwise such a write is dropped.
module i2s_buf_audio_in
  import buf_audio_in_pkg::*;
#(
  parameter int NUM_AUDIO_CHANNELS = 1
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   adv_read_enable,
  input  logic                   i2s_bclk,
  input  logic                   i2s_lrclk,
  input  logic                   i2s_data,
  output logic [AUDIO_WIDTH-1:0] audio_channel_out [NUM_AUDIO_CHANNELS*STEREO_MULTIPLIER],
  output logic                   sample_valid,
  output logic                   buffer_ready,
  output logic                   buffer_full
);

  logic [I2S_WIDTH-1:0] word;
  logic                 word_lr;
  logic                 word_done;

  i2s_rx_deser u_deser (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .i2s_bclk_i  (i2s_bclk),
    .i2s_lrclk_i (i2s_lrclk),
    .i2s_data_i  (i2s_data),
    .word_o      (word),
    .lr_o        (word_lr),
    .word_done_o (word_done)
  );

  asm_state_t             state_q, state_d;
  logic [AUDIO_WIDTH-1:0] left_q, right_q;
  logic                   left_valid_q;
  logic                   sample_valid_q;
  logic                   wr_en;
  mono_entry_t            wr_entry;
  logic                   rd_req_q, rd_prev_q;
  logic                   rd_rise;

  // Frame assembly: a Right word with a held Left word writes Left now and
  // Right two cycles later, leaving a gap so sample_valid shows two edges.
  always_comb begin
    state_d  = state_q;
    wr_en    = 1'b0;
    wr_entry = {1'b0, left_q};
    unique case (state_q)
      ASM_IDLE: begin
        if (word_done && word_lr && left_valid_q) begin
          wr_en    = 1'b1;
          wr_entry = {1'b0, left_q};
          state_d  = ASM_GAP;
        end
      end
      ASM_GAP: begin
        state_d = ASM_RIGHT;
      end
      ASM_RIGHT: begin
        wr_en    = 1'b1;
        wr_entry = {1'b1, right_q};
        state_d  = ASM_IDLE;
      end
      default: begin
        state_d = ASM_IDLE;
      end
    endcase
  end

  // Assembly registers: hold the Left word, capture the Right word, and
  // discard a Right word that arrives without a Left partner.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q        <= ASM_IDLE;
      left_q         <= '0;
      right_q        <= '0;
      left_valid_q   <= 1'b0;
      sample_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      sample_valid_q <= wr_en;
      if (word_done && !word_lr) begin
        left_q       <= word;
        left_valid_q <= 1'b1;
      end else if (word_done && word_lr) begin
        right_q      <= word;
        left_valid_q <= 1'b0;
      end
    end
  end

  assign sample_valid = sample_valid_q;

  // Read request edge detector; one pop per rising edge of adv_read_enable.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rd_req_q  <= 1'b0;
      rd_prev_q <= 1'b0;
    end else begin
      rd_req_q  <= adv_read_enable;
      rd_prev_q <= rd_req_q;
    end
  end

  assign rd_rise = rd_req_q & ~rd_prev_q;

  for (genvar gi = 0; gi < NUM_AUDIO_CHANNELS; gi++) begin : g_pair
    mono_entry_t            mem [FIFO_ENTRIES];
    mono_entry_t            rd_data_q;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   pop, is_full, do_write, evict;
    logic                   pop_q;
    logic [AUDIO_WIDTH-1:0] out_l_q, out_r_q;

    // FIFO control: pointer/count update including the full-FIFO policy.
    always_comb begin
      pop     = rd_rise && (count_q != '0);
      is_full = (count_q == CNT_FULL);
`ifdef BUF_AUDIO_IN_OVERWRITE_EN
      do_write = wr_en;
      evict    = wr_en && is_full && !pop;
`else
      do_write = wr_en && (!is_full || pop);
      evict    = 1'b0;
`endif
      wr_ptr_d = do_write ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = (pop || evict) ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      if (do_write && !pop && !evict) begin
        count_d = count_q + CNT_W'(1);
      end else if (!do_write && pop) begin
        count_d = count_q - CNT_W'(1);
      end
    end

    // Storage array with registered read so it maps onto block RAM.
    always_ff @(posedge sys_clk) begin
      if (do_write) begin
        mem[wr_ptr_q] <= wr_entry;
      end
      if (pop) begin
        rd_data_q <= mem[rd_ptr_q];
      end
    end

    // FIFO pointers, occupancy and pop pipeline flag.
    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        pop_q    <= 1'b0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
        pop_q    <= pop;
      end
    end

    // Popped sample steers to the Left or Right output by its tag.
    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        out_l_q <= '0;
        out_r_q <= '0;
      end else if (pop_q) begin
        if (rd_data_q.lr) begin
          out_r_q <= rd_data_q.data;
        end else begin
          out_l_q <= rd_data_q.data;
        end
      end
    end

    assign audio_channel_out[gi*STEREO_MULTIPLIER]     = out_l_q;
    assign audio_channel_out[gi*STEREO_MULTIPLIER + 1] = out_r_q;

    if (gi == 0) begin : g_status
      // Status flags reflect pair 0 and track the registered occupancy.
      always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
          buffer_full  <= 1'b0;
          buffer_ready <= 1'b0;
        end else begin
          buffer_full  <= (count_d == CNT_FULL);
          buffer_ready <= (count_d >= CNT_READY);
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_buf_audio_in.sv
// Self-checking bench for i2s_buf_audio_in with two stereo pairs.
module tb_i2s_buf_audio_in;

  localparam int NCH   = 2;
  localparam int NOUT  = NCH * 2;
  localparam int NENTR = 16;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        adv_read_enable = 1'b0;
  logic        i2s_bclk = 1'b0;
  logic        i2s_lrclk = 1'b1;
  logic        i2s_data = 1'b0;
  logic [23:0] audio_channel_out [NOUT];
  logic        sample_valid, buffer_ready, buffer_full;

  int n_cmp  = 0;
  int n_fail = 0;

  i2s_buf_audio_in #(.NUM_AUDIO_CHANNELS(NCH)) dut (
    .sys_clk          (sys_clk),
    .sys_rst          (sys_rst),
    .adv_read_enable  (adv_read_enable),
    .i2s_bclk         (i2s_bclk),
    .i2s_lrclk        (i2s_lrclk),
    .i2s_data         (i2s_data),
    .audio_channel_out(audio_channel_out),
    .sample_valid     (sample_valid),
    .buffer_ready     (buffer_ready),
    .buffer_full      (buffer_full)
  );

  always #5 sys_clk = ~sys_clk;

  // Behavioural model: queue of {lr, sample} plus expected output array.
  logic [24:0] mq [$];
  logic [23:0] exp_out [NOUT];
  bit          chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic model_write(input logic lr, input logic [23:0] d);
    if (mq.size() < NENTR) begin
      mq.push_back({lr, d});
    end else begin
`ifdef BUF_AUDIO_IN_OVERWRITE_EN
      void'(mq.pop_front());
      mq.push_back({lr, d});
`endif
    end
  endtask

  task automatic model_read();
    logic [24:0] e;
    if (mq.size() > 0) begin
      e = mq.pop_front();
      for (int p = 0; p < NCH; p++) exp_out[p*2 + int'(e[24])] = e[23:0];
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int k = 0; k < NOUT; k++) exp_out[k] = '0;
  endtask

  // Compare process: whenever the bench is quiescent, outputs must match the model.
  always @(negedge sys_clk) begin
    if (chk_en) begin
      for (int k = 0; k < NOUT; k++)
        check($sformatf("model out[%0d]", k), 32'(audio_channel_out[k]), 32'(exp_out[k]));
      check("model buffer_full", 32'(buffer_full), 32'(mq.size() == NENTR));
      check("model buffer_ready", 32'(buffer_ready), 32'(mq.size() >= 2));
      check("idle sample_valid", 32'(sample_valid), 32'(0));
    end
  end

  // Pulse monitor: counts sample_valid pulses, checks the 2-cycle spacing
  // inside each frame, and records when buffer_ready rises.
  int   cyc = 0;
  int   sv_cnt = 0;
  int   last_sv_cyc = -100;
  int   ready_rise_cyc = -1;
  logic ready_prev = 1'b0;
  always @(negedge sys_clk) begin
    cyc++;
    if (sample_valid) begin
      sv_cnt++;
      if (sv_cnt % 2 == 0) check("sample_valid spacing", 32'(cyc - last_sv_cyc), 32'(2));
      last_sv_cyc = cyc;
    end
    if (buffer_ready && !ready_prev) ready_rise_cyc = cyc;
    ready_prev = buffer_ready;
  end

  task automatic bclk_bit(input logic lr, input logic b);
    @(negedge sys_clk);
    i2s_lrclk = lr;
    i2s_data  = b;
    repeat (4) @(negedge sys_clk);
    i2s_bclk = 1'b1;
    repeat (4) @(negedge sys_clk);
    i2s_bclk = 1'b0;
  endtask

  task automatic send_word(input logic lr, input logic [23:0] val, input int nbits);
    logic [23:0] sh;
    sh = val;
    for (int b = 0; b < nbits; b++) begin
      bclk_bit(lr, sh[23]);
      sh = sh << 1;
    end
  endtask

  task automatic preamble();
    for (int b = 0; b < 4; b++) bclk_bit(1'b1, 1'b0);
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
    int base;
    chk_en = 1'b0;
    base = sv_cnt;
    send_word(1'b0, l, 32);
    send_word(1'b1, r, 32);
    for (int w = 0; w < 1000 && sv_cnt < base + 2; w++) @(negedge sys_clk);
    repeat (5) @(negedge sys_clk);
    check("frame sample_valid pulses", 32'(sv_cnt - base), 32'(2));
    model_write(1'b0, l);
    model_write(1'b1, r);
    chk_en = 1'b1;
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic do_read();
    chk_en = 1'b0;
    @(negedge sys_clk);
    adv_read_enable = 1'b1;
    repeat (2) @(negedge sys_clk);
    adv_read_enable = 1'b0;
    repeat (5) @(negedge sys_clk);
    model_read();
    chk_en = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    @(negedge sys_clk);
    sys_rst = 1'b1;
    repeat (5) @(negedge sys_clk);
    sys_rst = 1'b0;
    model_reset();
    @(negedge sys_clk);
    for (int k = 0; k < NOUT; k++) check("reset out", 32'(audio_channel_out[k]), 32'(0));
    check("reset sample_valid", 32'(sample_valid), 32'(0));
    check("reset buffer_ready", 32'(buffer_ready), 32'(0));
    check("reset buffer_full", 32'(buffer_full), 32'(0));
    chk_en = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] t_l, t_r;
    model_reset();
    do_reset();
    preamble();

    // Single frame, read back L then R; pair 1 mirrors pair 0.
    send_frame(24'h123456, 24'hABCDEF);
    do_read();
    check("t2 out0", 32'(audio_channel_out[0]), 32'h123456);
    check("t2 out2", 32'(audio_channel_out[2]), 32'h123456);
    do_read();
    check("t2 out1", 32'(audio_channel_out[1]), 32'hABCDEF);
    check("t2 out3", 32'(audio_channel_out[3]), 32'hABCDEF);
    do_read();
    check("empty pop holds out0", 32'(audio_channel_out[0]), 32'h123456);
    check("empty pop holds out1", 32'(audio_channel_out[1]), 32'hABCDEF);

    // Fill to full, then drain in order.
    for (int i = 0; i < 8; i++) send_frame(24'h100000 + 24'(i), 24'h200000 + 24'(i));
    check("t3 buffer_full", 32'(buffer_full), 32'(1));
    for (int i = 0; i < 8; i++) begin
      t_l = 24'h100000 + 24'(i);
      t_r = 24'h200000 + 24'(i);
      do_read();
      check("t3 drain L", 32'(audio_channel_out[0]), 32'(t_l));
      do_read();
      check("t3 drain R", 32'(audio_channel_out[1]), 32'(t_r));
    end
    check("t3 buffer_full after drain", 32'(buffer_full), 32'(0));

    // Overflow frame on a full FIFO.
    for (int i = 0; i < 8; i++) send_frame(24'h100000 + 24'(i), 24'h200000 + 24'(i));
    send_frame(24'hBEEF01, 24'hBEEF02);
    check("t4 buffer_full", 32'(buffer_full), 32'(1));
    do_read();
    do_read();
`ifdef BUF_AUDIO_IN_OVERWRITE_EN
    check("t4 first L", 32'(audio_channel_out[0]), 32'h100001);
    check("t4 first R", 32'(audio_channel_out[1]), 32'h200001);
`else
    check("t4 first L", 32'(audio_channel_out[0]), 32'h100000);
    check("t4 first R", 32'(audio_channel_out[1]), 32'h200000);
`endif
    for (int i = 0; i < 12; i++) do_read();
    do_read();
    do_read();
`ifdef BUF_AUDIO_IN_OVERWRITE_EN
    check("t4 last L", 32'(audio_channel_out[0]), 32'hBEEF01);
    check("t4 last R", 32'(audio_channel_out[1]), 32'hBEEF02);
`else
    check("t4 last L", 32'(audio_channel_out[0]), 32'h100007);
    check("t4 last R", 32'(audio_channel_out[1]), 32'h200007);
`endif

    // Reset in the middle of a Left word, then a clean frame.
    chk_en = 1'b0;
    send_word(1'b0, 24'hDEAD00, 12);
    do_reset();
    check("t5 ready after reset", 32'(buffer_ready), 32'(0));
    preamble();
    send_frame(24'h0A0B0C, 24'h0D0E0F);
    check("t5 buffer_ready", 32'(buffer_ready), 32'(1));
    check("t5 ready within 5 cycles", 32'((ready_rise_cyc >= last_sv_cyc) && (ready_rise_cyc <= last_sv_cyc + 5)), 32'(1));

    // Second pair mirrors the first.
    do_read();
    do_read();
    check("t6 out0", 32'(audio_channel_out[0]), 32'h0A0B0C);
    check("t6 out1", 32'(audio_channel_out[1]), 32'h0D0E0F);
    check("t6 out2", 32'(audio_channel_out[2]), 32'h0A0B0C);
    check("t6 out3", 32'(audio_channel_out[3]), 32'h0D0E0F);
    check("t6 ready after drain", 32'(buffer_ready), 32'(0));

    repeat (4) @(negedge sys_clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
